// File: rtl/req_pkg.sv
// Shared types and helpers for the two-channel request source.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package req_pkg;

    // Per-channel request FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVE   = 2'd2,
        RELEASE = 2'd3
    } ch_state_t;

    // Width needed to hold a pending count from 0 up to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/req_channel.sv
// One request channel: saturating job counter plus request/serve/release FSM.
// Latency: job in idle empty channel -> req next edge; done on the SVC_CYCLES+1th consecutive granted edge.
// Backpressure: jobs beyond DEPTH are dropped with an ovf pulse; req held until granted.
// Optional feature macro REQ_TIMEOUT_EN adds a sticky starve flag driven by a REQ wait counter.
module req_channel
    import req_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SVC_CYCLES = 2,
    parameter int TIMEOUT    = 16,
    localparam int CW        = count_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          job,
    input  logic          gnt,
    output logic          req,
    output logic [CW-1:0] pend,
    output logic          done,
    output logic          ovf
`ifdef REQ_TIMEOUT_EN
    ,
    output logic          starve
`endif
);

    localparam int SW = $clog2(SVC_CYCLES + 1);

    ch_state_t     state;
    ch_state_t     state_nxt;
    logic [SW-1:0] svc_cnt;
    logic [SW-1:0] svc_nxt;
    logic          complete;
    logic [CW-1:0] pend_nxt;
    logic          ovf_nxt;
    logic          full;

    assign full = (pend == CW'(DEPTH));

    // Next-state and service-count logic; complete marks the edge a job finishes.
    always_comb begin
        state_nxt = state;
        svc_nxt   = svc_cnt;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (pend != '0 || job) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (gnt) begin
                    state_nxt = SERVE;
                    svc_nxt   = SW'(1);
                end
            end
            SERVE: begin
                if (!gnt) begin
                    // Grant lost: the job restarts from scratch on the next grant.
                    state_nxt = REQ;
                    svc_nxt   = '0;
                end else if (svc_cnt < SW'(SVC_CYCLES)) begin
                    svc_nxt = svc_cnt + SW'(1);
                end else begin
                    complete  = 1'b1;
                    state_nxt = RELEASE;
                    svc_nxt   = '0;
                end
            end
            RELEASE: begin
                // One cycle with req low lets the arbiter fall back to idle.
                state_nxt = (pend != '0) ? REQ : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                svc_nxt   = '0;
            end
        endcase
    end

    // Pending counter: a job landing on a completion cancels out, never overflows.
    always_comb begin
        pend_nxt = pend;
        ovf_nxt  = 1'b0;
        if (job && !complete) begin
            if (full) begin
                ovf_nxt = 1'b1;
            end else begin
                pend_nxt = pend + CW'(1);
            end
        end else if (complete && !job) begin
            pend_nxt = pend - CW'(1);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            svc_cnt <= '0;
            pend    <= '0;
            req     <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            svc_cnt <= svc_nxt;
            pend    <= pend_nxt;
            req     <= (state_nxt == REQ) || (state_nxt == SERVE);
            done    <= complete;
            ovf     <= ovf_nxt;
        end
    end

`ifdef REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic [TW-1:0] wait_nxt;

    // Wait counter runs only while requesting, clears on entering service, saturates.
    always_comb begin
        wait_nxt = wait_cnt;
        if (state == REQ) begin
            if (gnt) begin
                wait_nxt = '0;
            end else if (wait_cnt != TW'(TIMEOUT)) begin
                wait_nxt = wait_cnt + TW'(1);
            end
        end
    end

    // Starve flag is sticky until reset once the wait limit is hit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            starve   <= starve | (wait_nxt == TW'(TIMEOUT));
        end
    end
`endif

endmodule

// File: rtl/req_source_pair.sv
// Two independent request channels feeding a two-client grant arbiter.
// Latency: req one edge after a job reaches an idle channel; done after SVC_CYCLES+1 granted edges.
// Backpressure: each channel queues up to DEPTH jobs, drops extras with ovf; optional REQ_TIMEOUT_EN adds starve flags.
module req_source_pair
    import req_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SVC_CYCLES = 2,
    parameter int TIMEOUT    = 16,
    localparam int CW        = count_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          job_0,
    input  logic          job_1,
    input  logic          gnt_0,
    input  logic          gnt_1,
    output logic          req_0,
    output logic          req_1,
    output logic [CW-1:0] pend_0,
    output logic [CW-1:0] pend_1,
    output logic          done_0,
    output logic          done_1,
    output logic          ovf_0,
    output logic          ovf_1
`ifdef REQ_TIMEOUT_EN
    ,
    output logic          starve_0,
    output logic          starve_1
`endif
);

    req_channel #(
        .DEPTH      (DEPTH),
        .SVC_CYCLES (SVC_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) u_ch0 (
        .clock  (clock),
        .reset  (reset),
        .job    (job_0),
        .gnt    (gnt_0),
        .req    (req_0),
        .pend   (pend_0),
        .done   (done_0),
        .ovf    (ovf_0)
`ifdef REQ_TIMEOUT_EN
        ,
        .starve (starve_0)
`endif
    );

    req_channel #(
        .DEPTH      (DEPTH),
        .SVC_CYCLES (SVC_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) u_ch1 (
        .clock  (clock),
        .reset  (reset),
        .job    (job_1),
        .gnt    (gnt_1),
        .req    (req_1),
        .pend   (pend_1),
        .done   (done_1),
        .ovf    (ovf_1)
`ifdef REQ_TIMEOUT_EN
        ,
        .starve (starve_1)
`endif
    );

endmodule

// File: tb/tb_req_source_pair.sv
// Bench for req_source_pair with a registered two-client priority arbiter in the loop.
// Latency: checks every cycle against a queue-level model, plus hand-computed literal points.
// Backpressure: arbiter grant masks (allow0/allow1) hold a channel ungranted on demand.
module tb_req_source_pair;

    localparam int DEPTH = 4;
    localparam int SVC   = 2;
    localparam int TMO   = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       job_0 = 1'b0;
    logic       job_1 = 1'b0;
    logic       gnt_0 = 1'b0;
    logic       gnt_1 = 1'b0;
    logic       req_0, req_1;
    logic [2:0] pend_0, pend_1;
    logic       done_0, done_1, ovf_0, ovf_1;
`ifdef REQ_TIMEOUT_EN
    logic       starve_0, starve_1;
`endif

    int checks = 0;
    int errors = 0;
    bit allow0 = 1'b1;
    bit allow1 = 1'b1;

    req_source_pair #(.DEPTH(DEPTH), .SVC_CYCLES(SVC), .TIMEOUT(TMO)) dut (
        .clock    (clock),
        .reset    (reset),
        .job_0    (job_0),
        .job_1    (job_1),
        .gnt_0    (gnt_0),
        .gnt_1    (gnt_1),
        .req_0    (req_0),
        .req_1    (req_1),
        .pend_0   (pend_0),
        .pend_1   (pend_1),
        .done_0   (done_0),
        .done_1   (done_1),
        .ovf_0    (ovf_0),
        .ovf_1    (ovf_1)
`ifdef REQ_TIMEOUT_EN
        ,
        .starve_0 (starve_0),
        .starve_1 (starve_1)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Registered priority arbiter: holds a grant while its client keeps requesting,
    // returns to idle when the request drops, and prefers client 0 from idle.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_0 <= 1'b0;
            gnt_1 <= 1'b0;
        end else if (gnt_0) begin
            gnt_0 <= req_0 && allow0;
        end else if (gnt_1) begin
            gnt_1 <= req_1 && allow1;
        end else if (req_0 && allow0) begin
            gnt_0 <= 1'b1;
        end else if (req_1 && allow1) begin
            gnt_1 <= 1'b1;
        end
    end

    // Behavioural model: a channel is "requesting" with a count of consecutive granted
    // cycles; the job finishes on the granted cycle after SVC have been banked.
    int m_pend [2];
    bit m_req  [2];
    int m_run  [2];
    bit m_rel  [2];
    bit m_done [2];
    bit m_ovf  [2];
    int m_wait [2];
    bit m_stv  [2];

    bit md_j, md_g, md_cpl, md_req, md_rel, md_ovf, md_stv;
    int md_pend, md_run, md_wait;

    always @(posedge clock or negedge reset) begin
        for (int c = 0; c < 2; c++) begin
            if (!reset) begin
                m_pend[c] <= 0; m_req[c] <= 0; m_run[c] <= 0; m_rel[c] <= 0;
                m_done[c] <= 0; m_ovf[c] <= 0; m_wait[c] <= 0; m_stv[c] <= 0;
            end else begin
                md_j   = (c == 0) ? job_0 : job_1;
                md_g   = (c == 0) ? gnt_0 : gnt_1;
                md_cpl = m_req[c] && md_g && (m_run[c] == SVC);
                md_pend = m_pend[c];
                md_ovf  = 1'b0;
                if (md_cpl && !md_j) md_pend = md_pend - 1;
                else if (md_j && !md_cpl) begin
                    if (md_pend < DEPTH) md_pend = md_pend + 1;
                    else md_ovf = 1'b1;
                end
                md_run = m_run[c];
                md_req = m_req[c];
                md_rel = 1'b0;
                if (md_cpl) begin
                    md_req = 1'b0; md_rel = 1'b1; md_run = 0;
                end else if (m_rel[c]) begin
                    md_req = (m_pend[c] > 0);
                end else if (!m_req[c]) begin
                    md_req = (m_pend[c] > 0) || md_j;
                end else if (md_g) begin
                    md_run = m_run[c] + 1;
                end else begin
                    md_run = 0;
                end
                md_wait = m_wait[c];
                if (m_req[c] && m_run[c] == 0) begin
                    if (md_g) md_wait = 0;
                    else if (md_wait < TMO) md_wait = md_wait + 1;
                end
                md_stv = m_stv[c] || (md_wait == TMO);
                m_pend[c] <= md_pend; m_req[c] <= md_req; m_run[c] <= md_run;
                m_rel[c]  <= md_rel;  m_done[c] <= md_cpl; m_ovf[c] <= md_ovf;
                m_wait[c] <= md_wait; m_stv[c] <= md_stv;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clock) begin
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("cmp req_%0d", c),  (c == 0) ? req_0 : req_1,   m_req[c]);
            chk($sformatf("cmp pend_%0d", c), (c == 0) ? pend_0 : pend_1, m_pend[c]);
            chk($sformatf("cmp done_%0d", c), (c == 0) ? done_0 : done_1, m_done[c]);
            chk($sformatf("cmp ovf_%0d", c),  (c == 0) ? ovf_0 : ovf_1,   m_ovf[c]);
`ifdef REQ_TIMEOUT_EN
            chk($sformatf("cmp starve_%0d", c), (c == 0) ? starve_0 : starve_1, m_stv[c]);
`endif
        end
    end

    task automatic drain(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (!req_0 && !req_1 && pend_0 == 3'd0 && pend_1 == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cnt;

        // Reset state.
        repeat (2) @(negedge clock);
        chk("rst req_0", req_0, 0);
        chk("rst pend_0", pend_0, 0);
        chk("rst done_0", done_0, 0);
        chk("rst ovf_1", ovf_1, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 1: single job_0.
        job_0 = 1'b1;
        @(negedge clock); job_0 = 1'b0;
        chk("t1 req_0 rise", req_0, 1);
        chk("t1 pend_0 one", pend_0, 1);
        chk("t1 gnt_0 not yet", gnt_0, 0);
        @(negedge clock);
        chk("t1 gnt_0", gnt_0, 1);
        @(negedge clock);
        chk("t1 done_0 early a", done_0, 0);
        @(negedge clock);
        chk("t1 done_0 early b", done_0, 0);
        @(negedge clock);
        chk("t1 done_0", done_0, 1);
        chk("t1 req_0 low", req_0, 0);
        chk("t1 pend_0 zero", pend_0, 0);
        @(negedge clock);
        chk("t1 done_0 pulse", done_0, 0);
        chk("t1 gnt_0 drop", gnt_0, 0);
        repeat (3) @(negedge clock);

        // 2: job_0 and job_1 together.
        job_0 = 1'b1; job_1 = 1'b1;
        @(negedge clock); job_0 = 1'b0; job_1 = 1'b0;
        chk("t2 pend_0", pend_0, 1);
        chk("t2 pend_1", pend_1, 1);
        repeat (4) @(negedge clock);
        chk("t2 done_0", done_0, 1);
        chk("t2 done_1 not yet", done_1, 0);
        repeat (2) @(negedge clock);
        chk("t2 gnt_1", gnt_1, 1);
        repeat (3) @(negedge clock);
        chk("t2 done_1", done_1, 1);
        chk("t2 pend_0 end", pend_0, 0);
        chk("t2 pend_1 end", pend_1, 0);
        repeat (3) @(negedge clock);

        // 3: six back-to-back job_1 pulses while channel 1 is ungranted.
        allow1 = 1'b0;
        job_1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("t3 pend_1 #%0d", i + 1), pend_1, (i < 4) ? i + 1 : 4);
            chk($sformatf("t3 ovf_1 #%0d", i + 1), ovf_1, (i >= 4) ? 1 : 0);
        end
        job_1 = 1'b0;
        @(negedge clock);
        chk("t3 ovf_1 stop", ovf_1, 0);
        allow1 = 1'b1;
        drain(300, ok);
        chk("t3 drain", ok, 1);

        // 4: job_0 lands on the completion edge while pend_0 is full.
        allow0 = 1'b0;
        job_0 = 1'b1;
        repeat (4) @(negedge clock);
        job_0 = 1'b0;
        chk("t4 pend_0 full", pend_0, 4);
        allow0 = 1'b1;
        @(negedge clock);
        chk("t4 gnt_0", gnt_0, 1);
        repeat (2) @(negedge clock);
        job_0 = 1'b1;
        @(negedge clock); job_0 = 1'b0;
        chk("t4 done_0", done_0, 1);
        chk("t4 pend_0 held", pend_0, 4);
        chk("t4 ovf_0 none", ovf_0, 0);
        drain(400, ok);
        chk("t4 drain", ok, 1);

        // 5: reset in SERVE.
        job_0 = 1'b1;
        @(negedge clock); job_0 = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t5 req_0 rst", req_0, 0);
        chk("t5 pend_0 rst", pend_0, 0);
        chk("t5 done_0 rst", done_0, 0);
        @(negedge clock); reset = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (done_0) cnt++;
        end
        chk("t5 no done after rst", cnt, 0);

`ifdef REQ_TIMEOUT_EN
        // 6: channel 0 kept busy, channel 1 starves.
        job_0 = 1'b1; job_1 = 1'b1;
        @(negedge clock); job_1 = 1'b0;
        for (int i = 0; i < 15; i++) @(negedge clock);
        chk("t6 starve_1 before", starve_1, 0);
        @(negedge clock);
        chk("t6 starve_1 set", starve_1, 1);
        repeat (4) @(negedge clock);
        job_0 = 1'b0;
        drain(400, ok);
        chk("t6 drain", ok, 1);
        chk("t6 starve_1 sticky", starve_1, 1);
        chk("t6 starve_0", starve_0, 0);
`endif

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_source_pair.md
Name: req_source_pair

Overview:
- Upstream stage of the two-client grant FSM (fsm_using_function). Produces its req_0/req_1 and consumes its gnt_0/gnt_1.
- Each of two channels queues incoming job pulses in a saturating pending counter.
- A channel raises req while work is pending and holds the grant for a fixed service length.
- It then drops req for one cycle so the arbiter returns to idle and can re-arbitrate.

Parameters:
- DEPTH, 4: maximum pending jobs per channel (at least 1).
- SVC_CYCLES, 2: number of granted cycles consumed per job (at least 1).
- TIMEOUT, 16: request-to-grant wait limit; used only with the optional feature.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- job_0  input  1  one-cycle pulse that enqueues one job on channel 0.
- job_1  input  1  one-cycle pulse that enqueues one job on channel 1.
- gnt_0  input  1  grant from the arbiter for channel 0 (registered by the arbiter).
- gnt_1  input  1  grant from the arbiter for channel 1.
- req_0  output  1  request to the arbiter, channel 0 (registered).
- req_1  output  1  request to the arbiter, channel 1 (registered).
- pend_0  output  CW  pending job count, channel 0. CW = $clog2(DEPTH+1).
- pend_1  output  CW  pending job count, channel 1.
- done_0  output  1  one-cycle pulse when a channel 0 job completes.
- done_1  output  1  one-cycle pulse when a channel 1 job completes.
- ovf_0  output  1  one-cycle pulse when a channel 0 job is dropped because the queue is full.
- ovf_1  output  1  one-cycle pulse when a channel 1 job is dropped.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs go to 0, pend counters go to 0, both channel FSMs go to IDLE.
  - Reset mid-service abandons the in-flight job; no done pulse is produced.
- The two channels are identical and independent; there is no coupling between them.
- Per-channel FSM, with req registered and high only in REQ and SERVE:
  - IDLE: if pend>0 or job pulse this cycle, go to REQ next cycle.
  - REQ: when gnt=1, go to SERVE and set svc_cnt=1. Otherwise stay in REQ.
  - SERVE, gnt=1 and svc_cnt<SVC_CYCLES: increment svc_cnt.
  - SERVE, gnt=1 and svc_cnt==SVC_CYCLES: go to RELEASE (req=0 next cycle), decrement pend, pulse done.
  - SERVE, gnt=0 (grant lost): go back to REQ and clear svc_cnt. The job is not completed.
  - RELEASE: lasts exactly one cycle; gnt is ignored. Then go to REQ if pend>0, else IDLE.
- Latency:
  - A job pulse in an IDLE, empty channel raises req on the next edge.
  - The earliest grant is one cycle later.
  - done is asserted SVC_CYCLES granted cycles after the first granted cycle.
- Counter rules:
  - job alone with pend<DEPTH: increment pend.
  - job with pend==DEPTH and no completion in the same cycle: pend unchanged, ovf pulses.
  - job coinciding with a completion: pend unchanged, no ovf (even when full).
  - Counters never wrap.
- Starvation: if the arbiter favours channel 0, channel 1 waits in REQ indefinitely. This is legal behaviour, not an error, unless the optional feature is enabled.

Optional Feature:
- Macro: REQ_TIMEOUT_EN.
- When defined:
  - Adds outputs starve_0 and starve_1, each 1 bit.
  - A per-channel wait counter counts cycles spent in REQ.
  - When the count reaches TIMEOUT, starve_x is set sticky high until reset.
  - req behaviour is unchanged.
  - The wait counter clears on entry to SERVE and saturates at TIMEOUT.
- When not defined: no starve ports and no wait counters are present.

Decomposition:
- Shared package req_pkg holds:
  - the channel state enum: IDLE, REQ, SERVE, RELEASE (2 bits);
  - the count-width function.
- Sub-module req_channel implements one channel: counter, FSM, optional wait counter.
- req_source_pair instantiates req_channel twice and wires the ports through.

Test Plan (DEPTH=4, SVC_CYCLES=2, connected to fsm_using_function):
1. Single job_0 pulse after reset:
   - req_0 rises on the next edge and gnt_0 follows one cycle later.
   - done_0 pulses after 2 granted cycles, then req_0 goes low and pend_0 goes 1→0.
2. job_0 and job_1 pulsed in the same cycle:
   - Channel 0 is served first, with done_0.
   - After channel 0's RELEASE cycle, gnt_1 asserts and done_1 follows.
   - Both pend counts end at 0.
3. Six job_1 pulses back-to-back while channel 1 is ungranted:
   - pend_1 saturates at 4.
   - ovf_1 pulses on pulses 5 and 6.
4. job_0 pulse exactly in channel 0's done cycle with pend_0=4:
   - pend_0 stays 4 and no ovf_0 pulses.
5. Reset asserted during SERVE:
   - req, pend and done go to 0 immediately.
   - No done pulse appears after reset releases.
6. With REQ_TIMEOUT_EN and channel 0 kept continuously busy:
   - starve_1 rises after 16 cycles in REQ.
   - starve_1 stays high after channel 1 is later granted.
